// File: rtl/uc_ctrl.sv
// Purpose: control unit for the 8-bit single-cycle microcontroller; decodes Opcode into datapath controls and tracks HALT/TRAP state plus debug counters.
// Latency: control outputs are combinational from state, Opcode and zero; state, illegal flag and counters update on the rising clk edge.
// Backpressure: none; the only stall is HALTED, which holds the PC until run is seen.
module uc_ctrl #(
  parameter int unsigned CNT_W        = 16,
  parameter logic [2:0]  ALUOP_LI     = 3'b001,
  parameter bit          TRAP_ILLEGAL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic             zero,
  input  logic             run,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we,
  output logic             wez,
  output logic [2:0]       ALUOp,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] icount,
  output logic [CNT_W-1:0] jcount
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_TRAP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_illegal;
  logic [CNT_W-1:0] r_icount;
  logic [CNT_W-1:0] r_jcount;

  // Opcode class decode
  logic w_is_alu;
  logic w_is_li;
  logic w_is_nop;
  logic w_is_ctl;
  logic w_is_illegal;

  assign w_is_alu     = Opcode[5];
  assign w_is_li      = (Opcode[5:2] == 4'b0100);
  assign w_is_nop     = (Opcode[5:2] == 4'b0001);
  assign w_is_ctl     = (Opcode[5:2] == 4'b0000);
  assign w_is_illegal = ~(w_is_alu | w_is_li | w_is_nop | w_is_ctl);

  // Ungated control values and bookkeeping strobes; reset masking happens at the ports
  logic       w_s_inc;
  logic       w_s_inm;
  logic       w_we;
  logic       w_wez;
  logic [2:0] w_aluop;
  logic       w_retire;
  logic       w_jump_taken;
  logic       w_set_illegal;

  // State register: async reset always lands in RUN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and decode: RUN decodes Opcode, HALTED waits for run, TRAP flows NOPs
  always_comb begin
    w_state_nxt   = r_state;
    w_s_inc       = 1'b1;
    w_s_inm       = 1'b0;
    w_we          = 1'b0;
    w_wez         = 1'b0;
    w_aluop       = 3'b000;
    w_retire      = 1'b0;
    w_jump_taken  = 1'b0;
    w_set_illegal = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_retire = ~w_is_illegal;
        if (w_is_alu) begin
          w_aluop = Opcode[4:2];
          w_we    = 1'b1;
          w_wez   = 1'b1;
        end else if (w_is_li) begin
          w_s_inm = 1'b1;
          w_aluop = ALUOP_LI;
          w_we    = 1'b1;
        end else if (w_is_nop) begin
          w_s_inc = 1'b1;
        end else if (w_is_ctl) begin
          case (Opcode[1:0])
            2'b00: begin
              w_s_inc      = 1'b0;
              w_jump_taken = 1'b1;
            end
            2'b01: begin
              w_s_inc      = ~zero;
              w_jump_taken = zero;
            end
            2'b10: begin
              w_s_inc      = zero;
              w_jump_taken = ~zero;
            end
            default: begin
              // HALT: target is its own address, so PC self-loops while halted
              w_s_inc     = 1'b0;
              w_state_nxt = ST_HALTED;
            end
          endcase
        end else begin
          // Illegal opcode behaves as a NOP this cycle
          w_set_illegal = 1'b1;
          if (TRAP_ILLEGAL) begin
            w_state_nxt = ST_TRAP;
          end
        end
      end
      ST_HALTED: begin
        // Resume steps the PC past the HALT in the same cycle
        w_s_inc = run;
        if (run) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_TRAP: begin
        w_s_inc = 1'b1;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // Sticky illegal-opcode flag, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_illegal <= 1'b0;
    end else if (w_set_illegal) begin
      r_illegal <= 1'b1;
    end
  end

  // Saturating retired-instruction counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_icount <= '0;
    end else if (w_retire && (r_icount != '1)) begin
      r_icount <= r_icount + CNT_ONE;
    end
  end

  // Saturating taken-jump counter (HALT excluded)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_jcount <= '0;
    end else if (w_jump_taken && (r_jcount != '1)) begin
      r_jcount <= r_jcount + CNT_ONE;
    end
  end

  // While reset is held the datapath sees a harmless PC+1 with no writes
  assign s_inc   = w_s_inc | ~reset;
  assign s_inm   = w_s_inm & reset;
  assign we      = w_we & reset;
  assign wez     = w_wez & reset;
  assign ALUOp   = reset ? w_aluop : 3'b000;

  assign halted  = (r_state == ST_HALTED);
  assign illegal = r_illegal;
  assign icount  = r_icount;
  assign jcount  = r_jcount;

endmodule

// File: tb/tb_uc_ctrl.sv
// Purpose: self-checking bench for uc_ctrl; two instances (16-bit counters with trap, 4-bit counters without trap) share one stimulus stream.
// Latency: a reference model advances on each rising edge; outputs are compared on every falling edge.
// Backpressure: none; all stimulus is fixed-length so the run always ends.
module tb_uc_ctrl;

  logic       clk    = 1'b0;
  logic       reset  = 1'b0;
  logic [5:0] Opcode = 6'b101000;
  logic       zero   = 1'b0;
  logic       run    = 1'b0;

  always #5 clk = ~clk;

  logic        a_s_inc, a_s_inm, a_we, a_wez, a_halted, a_illegal;
  logic [2:0]  a_alu;
  logic [15:0] a_icount, a_jcount;
  logic        b_s_inc, b_s_inm, b_we, b_wez, b_halted, b_illegal;
  logic [2:0]  b_alu;
  logic [3:0]  b_icount, b_jcount;

  uc_ctrl #(.CNT_W(16), .ALUOP_LI(3'b001), .TRAP_ILLEGAL(1'b1)) dut_a (
    .clk(clk), .reset(reset), .Opcode(Opcode), .zero(zero), .run(run),
    .s_inc(a_s_inc), .s_inm(a_s_inm), .we(a_we), .wez(a_wez), .ALUOp(a_alu),
    .halted(a_halted), .illegal(a_illegal), .icount(a_icount), .jcount(a_jcount)
  );

  uc_ctrl #(.CNT_W(4), .ALUOP_LI(3'b001), .TRAP_ILLEGAL(1'b0)) dut_b (
    .clk(clk), .reset(reset), .Opcode(Opcode), .zero(zero), .run(run),
    .s_inc(b_s_inc), .s_inm(b_s_inm), .we(b_we), .wez(b_wez), .ALUOp(b_alu),
    .halted(b_halted), .illegal(b_illegal), .icount(b_icount), .jcount(b_jcount)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // index 0 = dut_a (trap enabled, 16-bit), index 1 = dut_b (no trap, 4-bit)
  bit m_halt[2];
  bit m_trap[2];
  bit m_ill[2];
  int m_ic[2];
  int m_jc[2];

  function automatic int cmax(input int k);
    return (k == 0) ? 65535 : 15;
  endfunction

  // 0 ALU, 1 LI, 2 NOP, 3 J, 4 JZ, 5 JNZ, 6 HALT, 7 illegal
  function automatic int op_class(input int op);
    if (op >= 32) return 0;
    if (op >= 16 && op < 20) return 1;
    if (op >= 4 && op < 8) return 2;
    if (op < 4) return 3 + op;
    return 7;
  endfunction

  function automatic bit taken(input int cls, input bit z);
    return (cls == 3) || (cls == 4 && z) || (cls == 5 && !z);
  endfunction

  // Expected {s_inc, s_inm, we, wez, ALUOp}
  function automatic logic [6:0] exp_ctl(input int k, input int op, input bit z, input bit rn);
    logic       si = 1'b1;
    logic       sm = 1'b0;
    logic       w  = 1'b0;
    logic       wz = 1'b0;
    logic [2:0] al = 3'b000;
    int         cls;
    cls = op_class(op);
    if (reset !== 1'b1 || m_trap[k]) begin
      si = 1'b1;
    end else if (m_halt[k]) begin
      si = rn;
    end else if (cls == 0) begin
      w = 1'b1; wz = 1'b1; al = 3'((op / 4) % 8);
    end else if (cls == 1) begin
      sm = 1'b1; w = 1'b1; al = 3'b001;
    end else if (cls == 6) begin
      si = 1'b0;
    end else if (cls >= 3 && cls <= 5) begin
      si = !taken(cls, z);
    end
    return {si, sm, w, wz, al};
  endfunction

  always @(posedge clk or negedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        m_halt[k] <= 1'b0; m_trap[k] <= 1'b0; m_ill[k] <= 1'b0;
        m_ic[k] <= 0; m_jc[k] <= 0;
      end else if (m_trap[k]) begin
        m_trap[k] <= 1'b1;
      end else if (m_halt[k]) begin
        if (run) m_halt[k] <= 1'b0;
      end else if (op_class(int'(Opcode)) == 7) begin
        m_ill[k] <= 1'b1;
        if (k == 0) m_trap[k] <= 1'b1;
      end else begin
        if (m_ic[k] < cmax(k)) m_ic[k] <= m_ic[k] + 1;
        if (taken(op_class(int'(Opcode)), zero) && m_jc[k] < cmax(k)) m_jc[k] <= m_jc[k] + 1;
        if (op_class(int'(Opcode)) == 6) m_halt[k] <= 1'b1;
      end
    end
  end

  // Compare every cycle on the falling edge
  always @(negedge clk) begin
    check("A_ctl",     32'({a_s_inc, a_s_inm, a_we, a_wez, a_alu}), 32'(exp_ctl(0, int'(Opcode), zero, run)));
    check("A_halted",  32'(a_halted),  32'(m_halt[0]));
    check("A_illegal", 32'(a_illegal), 32'(m_ill[0]));
    check("A_icount",  32'(a_icount),  32'(m_ic[0]));
    check("A_jcount",  32'(a_jcount),  32'(m_jc[0]));
    check("B_ctl",     32'({b_s_inc, b_s_inm, b_we, b_wez, b_alu}), 32'(exp_ctl(1, int'(Opcode), zero, run)));
    check("B_halted",  32'(b_halted),  32'(m_halt[1]));
    check("B_illegal", 32'(b_illegal), 32'(m_ill[1]));
    check("B_icount",  32'(b_icount),  32'(m_ic[1]));
    check("B_jcount",  32'(b_jcount),  32'(m_jc[1]));
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic [5:0] op, input logic z, input logic r);
    Opcode = op; zero = z; run = r;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [5:0] trap_ops [4];
    trap_ops[0] = 6'b110000; trap_ops[1] = 6'b010000;
    trap_ops[2] = 6'b000000; trap_ops[3] = 6'b000011;

    // Held in reset with an ALU opcode present: outputs must be the reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_inc", 32'(a_s_inc), 32'd1);
    check("rst_we",    32'(a_we),    32'd0);
    check("rst_alu",   32'(a_alu),   32'd0);
    reset = 1'b1;

    // ALU 1_010_00
    #1;
    check("alu_op",  32'(a_alu), 32'd2);
    check("alu_wez", 32'({a_we, a_wez, a_s_inc, a_s_inm}), 32'b1110);
    @(posedge clk); #1;
    check("alu_icount", 32'(a_icount), 32'd1);
    cyc(6'b111100, 1'b1, 1'b0);

    // JZ both ways, then JNZ both ways
    cyc(6'b000001, 1'b1, 1'b0);
    cyc(6'b000001, 1'b0, 1'b0);
    check("jz_jcount", 32'(a_jcount), 32'd1);
    cyc(6'b000010, 1'b0, 1'b0);
    cyc(6'b000010, 1'b1, 1'b0);
    check("jnz_jcount", 32'(a_jcount), 32'd2);
    check("jnz_icount", 32'(a_icount), 32'd6);

    // LI with run high (ignored in RUN), J, NOP
    cyc(6'b010011, 1'b0, 1'b1);
    cyc(6'b000000, 1'b1, 1'b0);
    cyc(6'b000111, 1'b0, 1'b0);
    check("pre_halt_icount", 32'(a_icount), 32'd9);
    check("pre_halt_jcount", 32'(a_jcount), 32'd3);

    // HALT, five idle cycles, then resume
    cyc(6'b000011, 1'b0, 1'b0);
    check("halt_icount", 32'(a_icount), 32'd10);
    for (int i = 0; i < 5; i++) begin
      check("halt_hold", 32'({a_halted, a_s_inc, a_we}), 32'b100);
      cyc(6'b000011, 1'b0, 1'b0);
    end
    run = 1'b1;
    #1;
    check("resume_s_inc", 32'({a_halted, a_s_inc}), 32'b11);
    @(posedge clk); #1;
    check("resume_halted", 32'(a_halted), 32'd0);
    check("resume_icount", 32'(a_icount), 32'd10);
    cyc(6'b000100, 1'b0, 1'b0);

    // run held high through HALT entry: exactly one HALTED cycle
    cyc(6'b000011, 1'b0, 1'b1);
    check("runhi_halted", 32'(a_halted), 32'd1);
    cyc(6'b000011, 1'b0, 1'b1);
    check("runhi_resumed", 32'(a_halted), 32'd0);
    check("runhi_icount", 32'(a_icount), 32'd12);

    // Illegal opcode: A traps, B just flags it
    cyc(6'b010100, 1'b0, 1'b0);
    check("ill_a", 32'(a_illegal), 32'd1);
    check("ill_b", 32'(b_illegal), 32'd1);
    for (int i = 0; i < 4; i++) begin
      Opcode = trap_ops[i]; zero = 1'b0; run = 1'b0;
      #1;
      check("trap_ctl", 32'({a_s_inc, a_we, a_wez}), 32'b100);
      @(posedge clk); #1;
    end
    check("trap_icount", 32'(a_icount), 32'd12);
    check("trap_halted", 32'(a_halted), 32'd0);

    // Asynchronous reset mid-cycle (A in TRAP, B in HALTED)
    #2 reset = 1'b0;
    #1;
    check("arst_ill",    32'(a_illegal), 32'd0);
    check("arst_cnt",    32'({a_icount, a_jcount}), 32'd0);
    check("arst_b_halt", 32'(b_halted), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Asynchronous reset mid-HALT with an ALU opcode on the bus
    cyc(6'b000011, 1'b0, 1'b0);
    check("halt2", 32'(a_halted), 32'd1);
    Opcode = 6'b100100;
    #2 reset = 1'b0;
    #1;
    check("arst_halt", 32'(a_halted), 32'd0);
    check("arst_icnt", 32'(a_icount), 32'd0);
    check("arst_outs", 32'({a_s_inc, a_s_inm, a_we, a_wez, a_alu}), 32'b1000000);
    @(posedge clk); #1;
    reset = 1'b1;

    // Saturation of the 4-bit counters
    repeat (20) cyc(6'b000101, 1'b0, 1'b0);
    check("sat_b_icount", 32'(b_icount), 32'hF);
    check("sat_a_icount", 32'(a_icount), 32'd20);
    repeat (18) cyc(6'b000000, 1'b0, 1'b0);
    check("sat_b_jcount", 32'(b_jcount), 32'hF);
    check("sat_a_jcount", 32'(a_jcount), 32'd18);

    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uc_ctrl.md
Name: uc_ctrl

Overview:
- Control unit for the single-cycle 8-bit microcontroller datapath (16-bit instruction word, 10-bit PC).
- Takes the datapath's Opcode and registered zero flag; returns s_inc, s_inm, we, wez and ALUOp every cycle.
- Adds sequential behaviour on top of the decode: a HALT state with resume handshake, a sticky illegal-opcode trap, and saturating retired-instruction and taken-jump counters for debug and bench checking.

Parameters:
- CNT_W, 16, width of icount and jcount.
- ALUOP_LI, 3'b001, ALUOp issued for load-immediate (ALU passes operand B = inm).
- TRAP_ILLEGAL, 1, 1 = illegal opcode enters TRAP state; 0 = illegal executes as NOP and only sets illegal.

Ports:
- clk, input, 1, system clock, rising edge.
- reset, input, 1, asynchronous, active-low.
- Opcode, input, 6, instruction bits [15:10] from the datapath.
- zero, input, 1, registered zero flag from the datapath.
- run, input, 1, resume request; sampled only in HALTED.
- s_inc, output, 1, 1 = PC+1, 0 = PC <- dir_salto.
- s_inm, output, 1, 1 = immediate path.
- we, output, 1, register file write enable.
- wez, output, 1, zero flag write enable.
- ALUOp, output, 3, ALU operation.
- halted, output, 1, state == HALTED.
- illegal, output, 1, sticky illegal-opcode flag.
- icount, output, CNT_W, retired instructions (saturating).
- jcount, output, CNT_W, taken jumps (saturating).

Behaviour:
- Decode in RUN state; outputs are combinational from state, Opcode and zero. Unlisted outputs are 0.
  - 1aaaxx (ALU): ALUOp=aaa, we=1, wez=1, s_inc=1.
  - 0100xx (LI): s_inm=1, ALUOp=ALUOP_LI, we=1, s_inc=1.
  - 0001xx (NOP): s_inc=1.
  - 000000 (J): s_inc=0.
  - 000001 (JZ): s_inc=~zero.
  - 000010 (JNZ): s_inc=zero.
  - 000011 (HALT): s_inc=0. The assembler places the instruction's own address in [9:0], so the PC self-loops.
  - 0010xx, 0011xx, 0101xx, 0110xx, 0111xx: illegal.
- States: RUN, HALTED, TRAP. State is registered.
  - RUN -> HALTED on the edge where HALT is decoded.
  - RUN -> TRAP on an illegal opcode when TRAP_ILLEGAL=1.
  - HALTED, run=0: s_inc=0, we=0, wez=0, s_inm=0, ALUOp=000; state holds.
  - HALTED, run=1: s_inc=1 in the same cycle (PC steps past HALT), other outputs as above; HALTED -> RUN on that edge.
  - TRAP: s_inc=1, we=0, wez=0 (instructions flow as NOPs, no state change). TRAP is left only via reset.
- illegal: set on the edge an illegal opcode is decoded in RUN (either TRAP_ILLEGAL value); cleared only by reset.
- icount: +1 on each RUN-state edge with a legal opcode, HALT included. No increment in HALTED, TRAP, or the resume cycle. Saturates at all-ones.
- jcount: +1 on each RUN-state edge where J/JZ/JNZ gives s_inc=0. HALT is not counted. Saturates at all-ones.
- Reset (reset=0, asynchronous, any state): state=RUN, illegal=0, icount=0, jcount=0, halted=0.
  - While reset is held: s_inc=1, we=0, wez=0, s_inm=0, ALUOp=000, regardless of Opcode.
  - After deassertion, decode resumes at the first rising edge.
- Reset mid-HALT or mid-TRAP returns to RUN; no residual state.
- run asserted in RUN or TRAP is ignored. run held high through HALT entry resumes on the first HALTED cycle (1 cycle in HALTED).

Test Plan:
- Reset, then Opcode=1_010_00, zero=x → we=1, wez=1, ALUOp=010, s_inc=1, s_inm=0. icount=1 after the edge.
- Opcode=000001 with zero=1, then zero=0 → s_inc=0 then 1. jcount=1; JNZ shows the mirror behaviour.
- Opcode=000011, run=0 for 5 cycles, then run=1 → halted=1 for 5 cycles with s_inc=0 and we=0. Resume cycle gives s_inc=1; halted=0 on the next edge. icount increases by exactly 1.
- Opcode=0101_00, TRAP_ILLEGAL=1 → illegal=1, we=0 and wez=0 thereafter for every opcode, icount frozen. Reset clears all.
- CNT_W=4, 20 NOPs → icount saturates at 4'hF.
- Assert reset asynchronously mid-clock during HALTED → halted=0 and counters=0 immediately, before any edge. Outputs are the reset values listed in Behaviour.
